// File: rtl/mem_bus_unit.sv
// Byte/halfword request to 8-bit SRAM beat sequencer.
// Fixed-latency reads are reassembled little-endian into a 16-bit response.
module mem_bus_unit #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_half,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata
);

  typedef enum logic [2:0] {
    IDLE, BEAT0, BEAT1, WAIT, RESP
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t            state_q;
  logic              we_q;
  logic              half_q;
  logic [7:0]        whi_q;
  logic [7:0]        lo_q;
  logic [1:0]        cnt_q;
  logic              rsp_valid_q;
  logic [15:0]       rsp_rdata_q;
  logic              sram_en_q;
  logic              sram_we_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [7:0]        sram_wdata_q;
  logic [ADDR_W-1:0] base;

  // Halfword accesses are aligned down to an even byte address.
  assign base = {req_addr[ADDR_W-1:1], req_addr[0] & ~req_half};

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      half_q       <= 1'b0;
      whi_q        <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q      <= BEAT0;
            we_q         <= req_we;
            half_q       <= req_half;
            whi_q        <= req_wdata[15:8];
            sram_en_q    <= 1'b1;
            sram_we_q    <= req_we;
            sram_addr_q  <= base;
            sram_wdata_q <= req_wdata[7:0];
          end
        end
        BEAT0: begin
          if (half_q) begin
            state_q      <= BEAT1;
            sram_addr_q  <= {sram_addr_q[ADDR_W-1:1], 1'b1};
            sram_wdata_q <= whi_q;
          end else begin
            sram_en_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            state_q     <= we_q ? RESP : WAIT;
            rsp_valid_q <= we_q;
            cnt_q       <= CNT_INIT;
          end
        end
        BEAT1: begin
          sram_en_q   <= 1'b0;
          sram_we_q   <= 1'b0;
          state_q     <= we_q ? RESP : WAIT;
          rsp_valid_q <= we_q;
          cnt_q       <= CNT_INIT;
          // Low byte lands during the second beat when latency is one.
          if (!we_q && RD_LAT == 1) lo_q <= sram_rdata;
        end
        WAIT: begin
          if (half_q && cnt_q == 2'd1) lo_q <= sram_rdata;
          if (cnt_q == 2'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= half_q ? {sram_rdata, lo_q}
                                  : {8'h00, sram_rdata};
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Scoreboard bench for mem_bus_unit: two instances (RD_LAT=1/ADDR_W=16,
// RD_LAT=3/ADDR_W=12), each backed by a behavioural fixed-latency SRAM.
module tb_mem_bus_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        v1, v3, rq_we, rq_half;
  logic [15:0] rq_addr, rq_wdata;

  logic        rdy1, rv1, en1, we1;
  logic [15:0] rd1, a1;
  logic [7:0]  wd1, sr1;
  logic        rdy3, rv3, en3, we3;
  logic [15:0] rd3;
  logic [11:0] a3;
  logic [7:0]  wd3, sr3;

  mem_bus_unit #(.ADDR_W(16), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
    .req_we(rq_we), .req_half(rq_half), .req_addr(rq_addr),
    .req_wdata(rq_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
    .sram_en(en1), .sram_we(we1), .sram_addr(a1),
    .sram_wdata(wd1), .sram_rdata(sr1)
  );

  mem_bus_unit #(.ADDR_W(12), .RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
    .req_we(rq_we), .req_half(rq_half), .req_addr(rq_addr),
    .req_wdata(rq_wdata), .rsp_valid(rv3), .rsp_rdata(rd3),
    .sram_en(en3), .sram_we(we3), .sram_addr(a3),
    .sram_wdata(wd3), .sram_rdata(sr3)
  );

  logic [7:0] mem1 [0:65535];
  logic [7:0] mem3 [0:4095];
  logic [7:0] p1, p3a, p3b, p3c;
  assign sr1 = p1;
  assign sr3 = p3c;

  always @(posedge clk) begin
    if (en1 && we1) mem1[a1] <= wd1;
    p1 <= mem1[a1];
    if (en3 && we3) mem3[a3] <= wd3;
    p3a <= mem3[a3];
    p3b <= p3a;
    p3c <= p3b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic        sel;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  d;
  } beat_t;

  typedef struct packed {
    logic        sel;
    logic [15:0] rdata;
    logic [31:0] acc;
    logic [31:0] lat;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  always @(negedge clk) begin
    beat_t b;
    rsp_t  r;
    if (en1 && en3) chk("beat_overlap", 1, 0);
    if (en1 || en3) begin
      if (beat_q.size() == 0) begin
        chk("beat_unexpected", {15'd0, en3, 15'd0, en1}, 0);
      end else begin
        b = beat_q.pop_front();
        if (b.sel) begin
          chk("beat3_sel_we", {en3, we3}, {1'b1, b.we});
          chk("beat3_addr", {20'd0, a3}, {16'd0, b.addr});
          if (b.we) chk("beat3_wdata", {24'd0, wd3}, {24'd0, b.d});
        end else begin
          chk("beat1_sel_we", {en1, we1}, {1'b1, b.we});
          chk("beat1_addr", {16'd0, a1}, {16'd0, b.addr});
          if (b.we) chk("beat1_wdata", {24'd0, wd1}, {24'd0, b.d});
        end
      end
    end
    if (rv1 || rv3) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", {15'd0, rv3, 15'd0, rv1}, 0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_sel", {rv3, rv1}, r.sel ? 2'b10 : 2'b01);
        chk("rsp_rdata", {16'd0, r.sel ? rd3 : rd1}, {16'd0, r.rdata});
        chk("rsp_latency", cyc - r.acc, r.lat);
      end
    end
  end

  int last_acc = 0;
  int last_thr = 0;

  task automatic issue(input bit sel, input logic we_i, input logic half_i,
                       input logic [15:0] ad, input logic [15:0] wd,
                       input logic [15:0] rd, input int lat,
                       input logic [15:0] b0a, input logic [7:0] b0d,
                       input logic [15:0] b1a, input logic [7:0] b1d,
                       input bit first);
    int n = 0;
    rq_we = we_i;
    rq_half = half_i;
    rq_addr = ad;
    rq_wdata = wd;
    if (sel) v3 = 1'b1; else v1 = 1'b1;
    @(negedge clk);
    while (!(sel ? rdy3 : rdy1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", n, 0);
      v1 = 1'b0;
      v3 = 1'b0;
      return;
    end
    if (!first) chk("throughput", cyc - last_acc, last_thr);
    last_acc = cyc;
    last_thr = lat + 1;
    beat_q.push_back('{sel, we_i, b0a, b0d});
    if (half_i) beat_q.push_back('{sel, we_i, b1a, b1d});
    if (lat > 0) rsp_q.push_back('{sel, rd, cyc, lat});
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v3 = 1'b0;
    rq_addr = 16'hDEAD;
    rq_wdata = 16'h5A5A;
    rq_we = ~we_i;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v1 = 0; v3 = 0; rq_we = 0; rq_half = 0;
    rq_addr = 16'h0; rq_wdata = 16'h0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v1 = i[0];
      v3 = ~i[0];
      rq_we = 1'b1;
      @(negedge clk);
      chk("rst_ready", {rdy3, rdy1}, 2'b11);
      chk("rst_rsp_valid", {rv3, rv1}, 2'b00);
      chk("rst_sram_en_we", {en3, we3, en1, we1}, 4'b0000);
      chk("rst_rdata", {rd3, rd1}, 32'h0);
      chk("rst_addr_wdata", {a3, a1}, 28'h0);
      chk("rst_wdata", {wd3, wd1}, 16'h0);
    end
    v1 = 0;
    v3 = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 1, 1, 16'h0103, 16'hBEEF, 16'h0000, 3,
          16'h0102, 8'hEF, 16'h0103, 8'hBE, 1);
    issue(0, 0, 1, 16'h0102, 16'h0000, 16'hBEEF, 4,
          16'h0102, 8'h00, 16'h0103, 8'h00, 0);
    issue(0, 0, 0, 16'h0103, 16'h0000, 16'h00BE, 3,
          16'h0103, 8'h00, 16'h0000, 8'h00, 0);
    issue(0, 1, 0, 16'h2001, 16'h5634, 16'h00BE, 2,
          16'h2001, 8'h34, 16'h0000, 8'h00, 0);
    issue(0, 1, 0, 16'h2000, 16'h0012, 16'h00BE, 2,
          16'h2000, 8'h12, 16'h0000, 8'h00, 0);
    issue(0, 0, 1, 16'h2001, 16'h0000, 16'h3412, 4,
          16'h2000, 8'h00, 16'h2001, 8'h00, 0);
    issue(0, 0, 0, 16'h0102, 16'h0000, 16'h00EF, 3,
          16'h0102, 8'h00, 16'h0000, 8'h00, 0);
    drain();

    issue(1, 1, 1, 16'hF103, 16'hBEEF, 16'h0000, 3,
          16'h0102, 8'hEF, 16'h0103, 8'hBE, 1);
    issue(1, 0, 0, 16'h0103, 16'h0000, 16'h00BE, 5,
          16'h0103, 8'h00, 16'h0000, 8'h00, 0);
    issue(1, 0, 1, 16'hF102, 16'h0000, 16'hBEEF, 6,
          16'h0102, 8'h00, 16'h0103, 8'h00, 0);
    issue(1, 1, 0, 16'hA7FF, 16'h99C3, 16'hBEEF, 2,
          16'h07FF, 8'hC3, 16'h0000, 8'h00, 0);
    issue(1, 0, 0, 16'h07FF, 16'h0000, 16'h00C3, 5,
          16'h07FF, 8'h00, 16'h0000, 8'h00, 0);
    issue(1, 1, 1, 16'h07FE, 16'h1122, 16'h00C3, 3,
          16'h07FE, 8'h22, 16'h07FF, 8'h11, 0);
    issue(1, 0, 1, 16'h87FF, 16'h0000, 16'h1122, 6,
          16'h07FE, 8'h00, 16'h07FF, 8'h00, 0);
    drain();

    // Abort a halfword write during its second beat.
    rq_we = 1; rq_half = 1; rq_addr = 16'h3000; rq_wdata = 16'hAAAA;
    v1 = 1;
    @(negedge clk);
    chk("abort_ready", rdy1, 1);
    beat_q.push_back('{1'b0, 1'b1, 16'h3000, 8'hAA});
    @(posedge clk);
    #1 v1 = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_en_we", {en1, we1}, 2'b00);
    chk("abort_ready_rst", rdy1, 1);
    chk("abort_rdata", rd1, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", rdy1, 1);
    chk("post_rst_rsp", rv1, 0);
    @(posedge clk);
    #1;
    issue(0, 0, 0, 16'h0103, 16'h0000, 16'h00BE, 3,
          16'h0103, 8'h00, 16'h0000, 8'h00, 1);
    issue(0, 0, 0, 16'h3000, 16'h0000, 16'h00AA, 3,
          16'h3000, 8'h00, 16'h0000, 8'h00, 0);
    drain();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
